block_cmd_rx: RTL and testbench

- Hardware end of the software-to-hardware block-drawing channel.
- The Nios writes 32-bit command words to the block_data PIO. This block detects each new word, decodes it, and drives single-cell writes into the board memory.
- It reports progress back to software on the 2-bit drawing_status PIO.
- It sits between the nios_system instance and the board RAM that the VGA renderer reads.

---
 rtl/blk_cmd_pkg.sv | 40 ++++
 rtl/block_cmd_rx_if.sv | 31 +++
 rtl/block_cmd_rx.sv | 137 +++++++++++++
 tb/tb_block_cmd_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_cmd_pkg.sv
//------------------------------------------------------------------------------
// blk_cmd_pkg : command-word layout, opcodes, status codes and FSM states
//               shared by the block command receiver and its software mirror.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package blk_cmd_pkg;

  localparam int CMD_W = 32;

  localparam int TOG_BIT   = 31;
  localparam int OP_MSB    = 30;
  localparam int OP_LSB    = 28;
  localparam int ROW_MSB   = 27;
  localparam int ROW_LSB   = 23;
  localparam int COL_MSB   = 22;
  localparam int COL_LSB   = 19;
  localparam int COLOR_MSB = 18;
  localparam int COLOR_LSB = 16;

  localparam logic [2:0] OP_NOP         = 3'd0;
  localparam logic [2:0] OP_WRITE_CELL  = 3'd1;
  localparam logic [2:0] OP_CLEAR_BOARD = 3'd2;
  localparam logic [2:0] OP_FRAME_DONE  = 3'd3;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FRAME = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/block_cmd_rx_if.sv
//------------------------------------------------------------------------------
// block_cmd_rx_if : PIO command/status and board-memory write bundle.
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface block_cmd_rx_if
  import blk_cmd_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int COLOR_W = 3
);
  logic [CMD_W-1:0]   block_data;
  logic [1:0]         drawing_status;
  logic               board_we;
  logic [ADDR_W-1:0]  board_addr;
  logic [COLOR_W-1:0] board_wdata;
  logic               frame_pulse;

  modport master (
    output block_data,
    input  drawing_status, board_we, board_addr, board_wdata, frame_pulse
  );

  modport slave (
    input  block_data,
    output drawing_status, board_we, board_addr, board_wdata, frame_pulse
  );
endinterface

`default_nettype wire

// File: rtl/block_cmd_rx.sv
//------------------------------------------------------------------------------
// block_cmd_rx : detects toggled PIO command words, decodes them and drives
//                single-cell / full-board writes into the board memory.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module block_cmd_rx
  import blk_cmd_pkg::*;
#(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 8
) (
  input  wire logic     Clk,
  input  wire logic     Reset,
  block_cmd_rx_if.slave bus
);

  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  c_CELLS = CNT_W'(ROWS * COLS);
  localparam logic [ADDR_W-1:0] c_COLS  = ADDR_W'(COLS);

  state_t             r_state;
  logic [CMD_W-1:0]   r_d_q;
  logic               r_last_tog;
  logic [1:0]         r_status;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [COLOR_W-1:0] r_wdata;
  logic               r_frame;
  logic [CNT_W-1:0]   r_cnt;
  logic [4:0]         r_row;
  logic [3:0]         r_col;
  logic [2:0]         r_color;

  logic               w_pending;
  logic [2:0]         w_op;
  logic [4:0]         w_row;
  logic [3:0]         w_col;
  logic [2:0]         w_color;
  logic               w_in_range;
  logic [ADDR_W-1:0]  w_cell_addr;
  logic               w_unused_low;

  assign w_pending    = r_d_q[TOG_BIT] != r_last_tog;
  assign w_op         = r_d_q[OP_MSB:OP_LSB];
  assign w_row        = r_d_q[ROW_MSB:ROW_LSB];
  assign w_col        = r_d_q[COL_MSB:COL_LSB];
  assign w_color      = r_d_q[COLOR_MSB:COLOR_LSB];
  assign w_in_range   = (int'(w_row) < ROWS) && (int'(w_col) < COLS);
  assign w_cell_addr  = ADDR_W'(r_row) * c_COLS + ADDR_W'(r_col);
  assign w_unused_low = ^r_d_q[COLOR_LSB-1:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_d_q      <= '0;
      r_last_tog <= 1'b0;
      r_status   <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_frame    <= 1'b0;
      r_cnt      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_color    <= '0;
    end else begin
      r_d_q   <= bus.block_data;
      r_we    <= 1'b0;
      r_frame <= 1'b0;
      case (r_state)
        IDLE: begin
          // Toggles arriving while busy stay pending in r_d_q until we return here.
          if (w_pending) begin
            r_last_tog <= r_d_q[TOG_BIT];
            case (w_op)
              OP_NOP: r_status <= ST_IDLE;
              OP_WRITE_CELL: begin
                if (w_in_range) begin
                  r_row    <= w_row;
                  r_col    <= w_col;
                  r_color  <= w_color;
                  r_status <= ST_IDLE;
                  r_state  <= WRITE;
                end else begin
                  r_status <= ST_ERR;
                end
              end
              OP_CLEAR_BOARD: begin
                r_cnt    <= '0;
                r_status <= ST_BUSY;
                r_state  <= CLEAR;
              end
              OP_FRAME_DONE: begin
                r_frame  <= 1'b1;
                r_status <= ST_FRAME;
              end
              default: r_status <= ST_ERR;
            endcase
          end
        end
        WRITE: begin
          r_we     <= 1'b1;
          r_addr   <= w_cell_addr;
          r_wdata  <= COLOR_W'(r_color);
          r_status <= ST_IDLE;
          r_state  <= IDLE;
        end
        CLEAR: begin
          // Extra terminal cycle keeps status busy for the whole write burst.
          if (r_cnt == c_CELLS) begin
            r_status <= ST_IDLE;
            r_state  <= IDLE;
          end else begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= '0;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.drawing_status = r_status;
  assign bus.board_we       = r_we;
  assign bus.board_addr     = r_addr;
  assign bus.board_wdata    = r_wdata;
  assign bus.frame_pulse    = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_block_cmd_rx.sv
//------------------------------------------------------------------------------
// tb_block_cmd_rx : directed self-checking bench for block_cmd_rx.
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_block_cmd_rx;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic r_tog;

  block_cmd_rx_if #(.ADDR_W(8), .COLOR_W(3)) bus ();

  block_cmd_rx #(.ROWS(20), .COLS(10), .COLOR_W(3), .ADDR_W(8)) u_dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [4:0] row,
                       input logic [3:0] col, input logic [2:0] color);
    r_tog = ~r_tog;
    bus.block_data = {r_tog, op, row, col, color, 16'h0000};
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n_we;
    rst = 1'b1;
    r_tog = 1'b0;
    bus.block_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.board_we, bus.board_addr, bus.board_wdata, bus.frame_pulse, bus.drawing_status} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%0d wdata=%0d frame=%b status=%b, want all zero",
               bus.board_we, bus.board_addr, bus.board_wdata, bus.frame_pulse, bus.drawing_status);
    end
    rst = 1'b0;
    n_we = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.board_we === 1'b1) n_we++;
    end
    checks++;
    if (n_we !== 0) begin
      errors++;
      $display("FAIL idle_no_we: got %0d strobes, want 0", n_we);
    end
    checks++;
    if (bus.drawing_status !== 2'b00) begin
      errors++;
      $display("FAIL idle_status: got %b, want 00", bus.drawing_status);
    end
  endtask

  task automatic test_write();
    int n_we, at;
    logic [7:0] addr;
    logic [2:0] wd;
    issue(3'd1, 5'd3, 4'd7, 3'd5);
    n_we = 0; at = -1; addr = '0; wd = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.board_we === 1'b1) begin
        n_we++;
        at = i;
        addr = bus.board_addr;
        wd = bus.board_wdata;
      end
    end
    checks++;
    if (n_we !== 1 || at !== 3) begin
      errors++;
      $display("FAIL write_strobe: got %0d strobes at cycle %0d, want 1 at cycle 3", n_we, at);
    end
    checks++;
    if (addr !== 8'd37 || wd !== 3'd5) begin
      errors++;
      $display("FAIL write_data: got addr=%0d wdata=%0d, want addr=37 wdata=5", addr, wd);
    end
    checks++;
    if (bus.drawing_status !== 2'b00) begin
      errors++;
      $display("FAIL write_status: got %b, want 00", bus.drawing_status);
    end
  endtask

  task automatic test_range_error();
    int n_we;
    logic [7:0] addr;
    issue(3'd1, 5'd20, 4'd2, 3'd1);
    n_we = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.board_we === 1'b1) n_we++;
    end
    checks++;
    if (n_we !== 0 || bus.drawing_status !== 2'b11) begin
      errors++;
      $display("FAIL bad_row: got %0d strobes status=%b, want 0 strobes status=11", n_we, bus.drawing_status);
    end
    issue(3'd1, 5'd4, 4'd10, 3'd1);
    n_we = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.board_we === 1'b1) n_we++;
    end
    checks++;
    if (n_we !== 0 || bus.drawing_status !== 2'b11) begin
      errors++;
      $display("FAIL bad_col: got %0d strobes status=%b, want 0 strobes status=11", n_we, bus.drawing_status);
    end
    issue(3'd1, 5'd19, 4'd9, 3'd7);
    n_we = 0; addr = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.board_we === 1'b1) begin
        n_we++;
        addr = bus.board_addr;
      end
    end
    checks++;
    if (n_we !== 1 || addr !== 8'd199 || bus.drawing_status !== 2'b00) begin
      errors++;
      $display("FAIL corner_write: got %0d strobes addr=%0d status=%b, want 1 addr=199 status=00",
               n_we, addr, bus.drawing_status);
    end
  endtask

  task automatic test_clear_with_pending();
    int n_we, first, last, bad;
    logic [7:0] waddr;
    logic [2:0] wwd;
    issue(3'd2, 5'd0, 4'd0, 3'd0);
    n_we = 0; first = -1; last = -1; bad = 0; waddr = '1; wwd = '0;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (i == 30) issue(3'd1, 5'd0, 4'd0, 3'd6);
      if (bus.board_we === 1'b1) begin
        n_we++;
        if (n_we <= 200) begin
          if (first < 0) first = i;
          last = i;
          if (bus.board_addr !== 8'(n_we - 1) || bus.board_wdata !== 3'd0 ||
              bus.drawing_status !== 2'b01) begin
            if (bad == 0)
              $display("FAIL clear_beat: beat %0d got addr=%0d wdata=%0d status=%b, want addr=%0d wdata=0 status=01",
                       n_we, bus.board_addr, bus.board_wdata, bus.drawing_status, n_we - 1);
            bad++;
          end
        end else begin
          waddr = bus.board_addr;
          wwd = bus.board_wdata;
        end
      end
    end
    checks++;
    if (bad !== 0) errors++;
    checks++;
    if (n_we !== 201 || (last - first) !== 199) begin
      errors++;
      $display("FAIL clear_count: got %0d strobes span %0d, want 201 strobes clear span 199",
               n_we, last - first);
    end
    checks++;
    if (waddr !== 8'd0 || wwd !== 3'd6) begin
      errors++;
      $display("FAIL held_write: got addr=%0d wdata=%0d, want addr=0 wdata=6", waddr, wwd);
    end
    checks++;
    if (bus.drawing_status !== 2'b00) begin
      errors++;
      $display("FAIL clear_done_status: got %b, want 00", bus.drawing_status);
    end
  endtask

  task automatic test_frame_and_reserved();
    int n_fp;
    issue(3'd3, 5'd0, 4'd0, 3'd0);
    n_fp = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.frame_pulse === 1'b1) n_fp++;
    end
    checks++;
    if (n_fp !== 1) begin
      errors++;
      $display("FAIL frame_pulse: got %0d pulses, want 1", n_fp);
    end
    checks++;
    if (bus.drawing_status !== 2'b10) begin
      errors++;
      $display("FAIL frame_status: got %b, want 10", bus.drawing_status);
    end
    issue(3'd0, 5'd0, 4'd0, 3'd0);
    repeat (4) step();
    checks++;
    if (bus.drawing_status !== 2'b00) begin
      errors++;
      $display("FAIL nop_clears_frame: got %b, want 00", bus.drawing_status);
    end
    issue(3'd5, 5'd1, 4'd1, 3'd1);
    repeat (4) step();
    checks++;
    if (bus.drawing_status !== 2'b11 || bus.board_we !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op: got status=%b we=%b, want status=11 we=0", bus.drawing_status, bus.board_we);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n_we, first_addr, found;
    issue(3'd2, 5'd0, 4'd0, 3'd0);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (bus.board_we === 1'b1 && bus.board_addr === 8'd57) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL mid_clear_reach: got no write of addr 57, want one");
    end
    #2 rst = 1'b1;
    bus.block_data = '0;
    r_tog = 1'b0;
    #1;
    checks++;
    if ({bus.board_we, bus.board_addr, bus.board_wdata, bus.frame_pulse, bus.drawing_status} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got we=%b addr=%0d wdata=%0d frame=%b status=%b, want all zero",
               bus.board_we, bus.board_addr, bus.board_wdata, bus.frame_pulse, bus.drawing_status);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) step();
    issue(3'd2, 5'd0, 4'd0, 3'd0);
    n_we = 0; first_addr = -1;
    for (int i = 0; i < 230; i++) begin
      step();
      if (bus.board_we === 1'b1) begin
        if (n_we == 0) first_addr = int'(bus.board_addr);
        n_we++;
      end
    end
    checks++;
    if (first_addr !== 0 || n_we !== 200) begin
      errors++;
      $display("FAIL restart_clear: got first addr=%0d strobes=%0d, want first addr=0 strobes=200",
               first_addr, n_we);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    r_tog = 1'b0;
    bus.block_data = '0;
    test_reset();
    test_write();
    test_range_error();
    test_clear_with_pending();
    test_frame_and_reserved();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
